dds_sweep_sched: RTL and testbench

//  - Table-driven scheduler that sequences the DDS/DA wave generator through a programmed list of
//    (waveform, frequency word, dwell) entries; supports single-shot or looped sweeps.
//  - Sits between the key/host control logic and the DDS datapath (phase accumulator + wave ROM):

---
 rtl/dds_sweep_sched.sv | 186 ++++++++++++++++++
 tb/tb_dds_sweep_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_sched.sv
// Table-driven DDS sweep scheduler: steps wave_sel/fword through a programmed entry list.
// Define DDS_SCHED_PAUSE_EN to let pause freeze the dwell count; otherwise pause is ignored.
module dds_sweep_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int FW    = 24,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [1:0]    cfg_wave,
    input  logic [FW-1:0] cfg_fword,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [AW-1:0] last_idx,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    output logic [1:0]    wave_sel,
    output logic [FW-1:0] fword,
    output logic          upd,
    output logic          busy,
    output logic [AW-1:0] entry_idx,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        APPLY,
        DWELL,
        DONE
    } state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nx;
    state_t        adv_state;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nx;
    logic [AW-1:0] adv_idx;
    logic [AW-1:0] last_eff;
    logic [DW-1:0] cnt;
    logic [DW-1:0] stage_dwell;
    logic [DW-1:0] dwell_m1;
    logic          at_end;
    logic          ld_stage;
    logic          ld_cnt;
    logic          dec_cnt;
    logic          set_done;
    logic          hold;
    logic          wr_ok;

    logic [1:0]    tab_wave  [DEPTH];
    logic [FW-1:0] tab_fword [DEPTH];
    logic [DW-1:0] tab_dwell [DEPTH];

`ifdef DDS_SCHED_PAUSE_EN
    assign hold = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign hold = 1'b0;
`endif

    assign wr_ok = cfg_we && ({1'b0, cfg_addr} < DEPTH_W);

    // Table holds no reset: contents survive rst_n so a host need not reload.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tab_wave[cfg_addr]  <= cfg_wave;
            tab_fword[cfg_addr] <= cfg_fword;
            tab_dwell[cfg_addr] <= cfg_dwell;
        end
    end

    assign last_eff = ({1'b0, last_idx} >= DEPTH_W) ? LAST_MAX : last_idx;
    assign at_end   = (idx >= last_eff);
    assign dwell_m1 = (stage_dwell == '0) ? '0 : stage_dwell - 1'b1;
    assign busy     = (state != IDLE);

    always_comb begin
        adv_idx   = idx + 1'b1;
        adv_state = FETCH;
        if (at_end) begin
            adv_idx   = '0;
            adv_state = loop_en ? FETCH : DONE;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        ld_stage = 1'b0;
        ld_cnt   = 1'b0;
        dec_cnt  = 1'b0;
        set_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx = FETCH;
                    idx_nx   = '0;
                end
            end
            FETCH: begin
                ld_stage = 1'b1;
                state_nx = APPLY;
            end
            APPLY: begin
                if (!hold) begin
                    ld_cnt = 1'b1;
                    if (dwell_m1 == '0) begin
                        state_nx = adv_state;
                        idx_nx   = adv_idx;
                    end else begin
                        state_nx = DWELL;
                    end
                end
            end
            DWELL: begin
                if (!hold) begin
                    dec_cnt = 1'b1;
                    if (cnt <= DW'(1)) begin
                        state_nx = adv_state;
                        idx_nx   = adv_idx;
                    end
                end
            end
            DONE: begin
                set_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (stop && state != IDLE) begin
            state_nx = IDLE;
            idx_nx   = idx;
            ld_stage = 1'b0;
            ld_cnt   = 1'b0;
            dec_cnt  = 1'b0;
            set_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Outputs load as the fetch completes, so the new setting and upd appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            stage_dwell <= '0;
            wave_sel    <= '0;
            fword       <= '0;
            entry_idx   <= '0;
            upd         <= 1'b0;
            done        <= 1'b0;
        end else begin
            upd  <= ld_stage;
            done <= set_done;
            if (ld_stage) begin
                wave_sel    <= tab_wave[idx];
                fword       <= tab_fword[idx];
                stage_dwell <= tab_dwell[idx];
                entry_idx   <= idx;
            end
            if (ld_cnt) begin
                cnt <= dwell_m1;
            end else if (dec_cnt) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_sched.sv
// Self-checking bench for dds_sweep_sched against an event-time reference model.
// Pause expectations follow DDS_SCHED_PAUSE_EN.
module tb_dds_sweep_sched;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int FW    = 24;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [1:0]    cfg_wave = '0;
    logic [FW-1:0] cfg_fword = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic [AW-1:0] last_idx = '0;
    logic          loop_en = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic [1:0]    wave_sel;
    logic [FW-1:0] fword;
    logic          upd;
    logic          busy;
    logic [AW-1:0] entry_idx;
    logic          done;

    dds_sweep_sched #(.DEPTH(DEPTH), .AW(AW), .FW(FW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wave(cfg_wave), .cfg_fword(cfg_fword), .cfg_dwell(cfg_dwell),
        .last_idx(last_idx), .loop_en(loop_en), .start(start), .stop(stop),
        .pause(pause), .wave_sel(wave_sel), .fword(fword), .upd(upd),
        .busy(busy), .entry_idx(entry_idx), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]    m_wave [DEPTH];
    logic [FW-1:0] m_fw   [DEPTH];
    logic [DW-1:0] m_dw   [DEPTH];
    logic [1:0]    cur_wave = '0;
    logic [FW-1:0] cur_fw = '0;
    logic [AW-1:0] cur_idx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [1:0] w, input logic [FW-1:0] f,
                      input logic [DW-1:0] d);
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_wave = w;
        cfg_fword = f;
        cfg_dwell = d;
        m_wave[a] = w;
        m_fw[a] = f;
        m_dw[a] = d;
        step();
        cfg_we = 1'b0;
    endtask

    function automatic bit paused(input int c, input int pa, input int pl);
`ifdef DDS_SCHED_PAUSE_EN
        return (c >= pa) && (c < pa + pl);
`else
        return 1'b0;
`endif
    endfunction

    // Model: upd two cycles after start; each entry consumes max(dwell,1) unpaused
    // cycles, then one fetch cycle before the next upd (or the done pulse).
    task automatic run(input int last, input bit lp, input int hz, input int rs_at,
                       input int pa, input int pl, input int wr_at, input int wa,
                       input logic [FW-1:0] wf);
        int tupd[$];
        int tent[$];
        int tdone;
        int t;
        int i;
        int rem;
        int c;
        int k;
        int endc;
        bit eu;
        t = 2;
        i = 0;
        tdone = -1;
        while (t <= hz + 1) begin
            tupd.push_back(t);
            tent.push_back(i);
            rem = (m_dw[i] == 0) ? 1 : int'(m_dw[i]);
            c = t;
            while (rem > 0) begin
                if (!paused(c, pa, pl)) rem--;
                c++;
            end
            t = c + 1;
            if (i >= last) begin
                if (lp) i = 0;
                else begin
                    tdone = t;
                    break;
                end
            end else begin
                i++;
            end
        end
        endc = lp ? hz + 4 : tdone + 2;
        last_idx = AW'(last);
        loop_en = lp;
        start = 1'b1;
        k = 0;
        for (int r = 1; r <= endc; r++) begin
            step();
            eu = 1'b0;
            if (k < tupd.size() && tupd[k] == r) begin
                if (!lp || r <= hz) begin
                    eu = 1'b1;
                    cur_wave = m_wave[tent[k]];
                    cur_fw = m_fw[tent[k]];
                    cur_idx = AW'(tent[k]);
                end
                k++;
            end
            chk("upd", 32'(upd), 32'(eu));
            chk("done", 32'(done), 32'(!lp && r == tdone));
            chk("busy", 32'(busy), 32'(lp ? (r <= hz) : (r < tdone)));
            chk("wave_sel", 32'(wave_sel), 32'(cur_wave));
            chk("fword", 32'(fword), 32'(cur_fw));
            chk("entry_idx", 32'(entry_idx), 32'(cur_idx));
            start = (r == rs_at);
            stop = lp && (r == hz);
            pause = (r >= pa) && (r < pa + pl);
            cfg_we = (r == wr_at);
            cfg_addr = AW'(wa);
            cfg_wave = m_wave[wa];
            cfg_fword = wf;
            cfg_dwell = m_dw[wa];
        end
        start = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        cfg_we = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_wave", 32'(wave_sel), 32'd0);
        chk("rst_fword", 32'(fword), 32'd0);
        chk("rst_upd", 32'(upd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(entry_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();

        wr(0, 2'd0, 24'h001000, 16'd4);
        wr(1, 2'd1, 24'h002000, 16'd1);
        wr(2, 2'd3, 24'h004000, 16'd0);
        run(2, 1'b0, 1000, 0, 0, 0, 0, 0, '0);
        run(2, 1'b1, 30, 0, 0, 0, 0, 0, '0);

        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_busy", 32'(busy), 32'd0);
        step();
        chk("ss_busy2", 32'(busy), 32'd0);
        chk("ss_upd", 32'(upd), 32'd0);

        wr(0, 2'd1, 24'h003000, 16'd10);
        run(1, 1'b0, 1000, 5, 0, 0, 0, 0, '0);

        wr(0, 2'd2, 24'h005000, 16'd20);
        wr(1, 2'd2, 24'h011111, 16'd3);
        m_fw[1] = 24'h0ABCDE;
        run(1, 1'b0, 1000, 0, 0, 0, 5, 1, 24'h0ABCDE);

        wr(0, 2'd3, 24'h00C000, 16'd8);
        wr(1, 2'd0, 24'h00D000, 16'd2);
        run(1, 1'b0, 1000, 0, 4, 5, 0, 0, '0);

        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < DEPTH; j++)
                wr(j, 2'($urandom_range(0, 3)), 24'($urandom), 16'($urandom_range(0, 5)));
            run(int'($urandom_range(0, 7)), 1'b0, 1000, 0, 0, 0, 0, 0, '0);
        end
        run(int'($urandom_range(0, 7)), 1'b1, int'($urandom_range(20, 50)), 0, 0, 0, 0, 0, '0);

        wr(0, 2'd1, 24'h00F0F0, 16'd20);
        last_idx = '0;
        loop_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wave", 32'(wave_sel), 32'd0);
        chk("arst_fword", 32'(fword), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_idx", 32'(entry_idx), 32'd0);
        chk("arst_upd", 32'(upd), 32'd0);
        #10;
        rst_n = 1'b1;
        for (int r = 0; r < 30; r++) begin
            step();
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
